// File: rtl/drum_memory_unit.sv
// ---------------------------------------------------------------------------
// drum_memory_unit
//
// Magnetic-drum main store. It serves the one-cycle read and write requests
// issued by the pulse distributor. Rotational latency is emulated: a word can
// only be touched while its slot passes under the read/write head. Every
// accepted request produces a single-cycle completion pulse.
//
// Parameters
//   ADDR_W       address width; the drum holds 2**ADDR_W words per revolution
//   WORD_W       data word width
//   SLOT_CYCLES  clock cycles each word slot spends under the head (>=1)
//
// Ports
//   clk              in   rising-edge system clock
//   reset            in   asynchronous, active-high reset
//   mem_read_pulse   in   one-cycle read request
//   mem_write_pulse  in   one-cycle write request
//   mem_addr         in   word address, sampled together with the request
//   mem_wdata        in   write data, sampled together with the request
//   mem_reply        out  one-cycle completion pulse for reads and writes
//   mem_rdata        out  read data; valid with mem_reply, held until the
//                         next read completes
//   busy             out  high whenever a request is in flight
//   proto_err        out  sticky protocol-error flag, cleared only by reset
//   head_pos         out  word slot currently under the head (debug)
// ---------------------------------------------------------------------------
module drum_memory_unit #(
  parameter int ADDR_W      = 10,
  parameter int WORD_W      = 31,
  parameter int SLOT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_pulse,
  input  logic              mem_write_pulse,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic              mem_reply,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              proto_err,
  output logic [ADDR_W-1:0] head_pos
);

  // A single-cycle slot still needs a one-bit counter so the logic below
  // stays uniform; the counter then simply sits at zero.
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEEK  = 2'd1;
  localparam logic [1:0] ST_REPLY = 2'd2;

  logic [1:0]        state;
  logic [SLOT_W-1:0] slot_cnt;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              op_write_q;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  logic any_req;
  logic both_req;
  logic access_hit;

  // The head position is the drum angle expressed in word slots.
  assign head_pos = pos;
  assign busy     = (state != ST_IDLE);

  // Request decoding. A request is exactly one of the two pulses; seeing
  // both together is malformed and never starts an access.
  assign any_req  = mem_read_pulse | mem_write_pulse;
  assign both_req = mem_read_pulse & mem_write_pulse;

  // The latched word is under the head during the last cycle of its slot.
  // Using the last cycle means a request that arrives exactly then has just
  // missed the word and waits a full revolution.
  assign access_hit = (pos == addr_q) && (slot_cnt == SLOT_LAST);

  // Drum rotation. The slot counter and the position advance every cycle,
  // independent of the FSM, so the drum never stops spinning while a request
  // is pending or idle. The position wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_cnt <= '0;
      pos      <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      pos      <= pos + ADDR_W'(1);
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Request FSM. IDLE latches a well-formed request and moves to SEEK; SEEK
  // waits for the access point, performs the read, and moves to REPLY; REPLY
  // lasts exactly one cycle. mem_reply is a flop loaded on the SEEK-to-REPLY
  // transition so it is high for precisely the REPLY cycle and has no
  // combinational path from the request inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      mem_reply  <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_reply <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req && !both_req) begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            op_write_q <= mem_write_pulse;
            state      <= ST_SEEK;
          end
        end
        ST_SEEK: begin
          if (access_hit) begin
            if (!op_write_q) begin
              mem_rdata <= mem[addr_q];
            end
            mem_reply <= 1'b1;
            state     <= ST_REPLY;
          end
        end
        ST_REPLY: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Protocol error tracking. Both pulses together in IDLE, or any pulse
  // while a request is in flight (including the REPLY cycle), is recorded.
  // The offending pulse itself is simply dropped by the FSM above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if ((state == ST_IDLE && both_req) ||
                 (state != ST_IDLE && any_req)) begin
      proto_err <= 1'b1;
    end
  end

  // Storage array. It has no reset so that drum contents survive a reset.
  // A write only lands at the access point while in SEEK; a reset before
  // that point returns the FSM to IDLE, so an unfinished write is lost.
  always_ff @(posedge clk) begin
    if (state == ST_SEEK && access_hit && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_drum_memory_unit.sv
module tb_drum_memory_unit;

  localparam int AW = 3;
  localparam int WW = 31;
  localparam int SC = 2;
  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [WW-1:0] wdata = '0;
  logic          mem_reply;
  logic [WW-1:0] mem_rdata;
  logic          busy;
  logic          proto_err;
  logic [AW-1:0] head_pos;

  int checks = 0;
  int errors = 0;

  drum_memory_unit #(.ADDR_W(AW), .WORD_W(WW), .SLOT_CYCLES(SC)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read_pulse(rd),
    .mem_write_pulse(wr),
    .mem_addr(addr),
    .mem_wdata(wdata),
    .mem_reply(mem_reply),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .proto_err(proto_err),
    .head_pos(head_pos)
  );

  always #5 clk = ~clk;

  // Behavioural model: time is the cycle count since reset release, the drum
  // angle is plain division of that count, and a pending request completes
  // one cycle after the first access-point cycle strictly after its request.
  int            m_n;
  bit            m_pend;
  bit            m_pw;
  int            m_addr;
  int            m_req;
  int            m_reply;
  logic [WW-1:0] m_wdata;
  logic [WW-1:0] m_rdata;
  logic [WW-1:0] m_mem [NW];
  bit            m_err;

  typedef struct {
    int            n;
    bit            r;
    bit            w;
    int            a;
    logic [WW-1:0] d;
  } ev_t;

  typedef struct {
    int            n;
    int            sig;
    logic [WW-1:0] v;
  } lit_t;

  ev_t  evq[$];
  lit_t litq[$];

  function automatic int next_access(int t, int a);
    int r;
    r = -1;
    for (int m = t + 1; m <= t + NW * SC + 1; m++) begin
      if (r < 0 && ((m / SC) % NW) == a && (m % SC) == SC - 1) r = m;
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] word_init(int i);
    return WW'(32'h0AB0_0000 + i);
  endfunction

  task automatic checkVal(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d: got 0x%0h expected 0x%0h", name, m_n, act, exp);
    end
  endtask

  task automatic checkOutput();
    bit exp_busy;
    bit exp_reply;
    if (m_pend && m_n == m_reply) begin
      if (m_pw) m_mem[m_addr] = m_wdata;
      else      m_rdata = m_mem[m_addr];
    end
    exp_busy  = m_pend && (m_n > m_req) && (m_n <= m_reply);
    exp_reply = m_pend && (m_n == m_reply);
    checkVal("mem_reply", WW'(mem_reply), WW'(exp_reply));
    checkVal("busy", WW'(busy), WW'(exp_busy));
    checkVal("proto_err", WW'(proto_err), WW'(m_err));
    checkVal("head_pos", WW'(head_pos), WW'((m_n / SC) % NW));
    checkVal("mem_rdata", mem_rdata, m_rdata);
  endtask

  task automatic applyStimulus(bit r, bit w, int a, logic [WW-1:0] d);
    bit busy_now;
    bit err_next;
    checkOutput();
    busy_now = m_pend && (m_n > m_req) && (m_n <= m_reply);
    rd    = r;
    wr    = w;
    addr  = a[AW-1:0];
    wdata = d;
    if (m_pend && m_n == m_reply) m_pend = 1'b0;
    err_next = 1'b0;
    if (r || w) begin
      if (busy_now || (r && w)) begin
        err_next = 1'b1;
      end else begin
        m_pend  = 1'b1;
        m_pw    = w;
        m_addr  = a;
        m_wdata = d;
        m_req   = m_n;
        m_reply = next_access(m_n, a) + 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    if (err_next) m_err = 1'b1;
    m_n++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    checkVal("rst_busy", WW'(busy), WW'(0));
    checkVal("rst_reply", WW'(mem_reply), WW'(0));
    checkVal("rst_proto_err", WW'(proto_err), WW'(0));
    checkVal("rst_head_pos", WW'(head_pos), WW'(0));
    checkVal("rst_rdata", mem_rdata, WW'(0));
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_n     = 0;
    m_pend  = 1'b0;
    m_err   = 1'b0;
    m_rdata = '0;
  endtask

  task automatic checkLit(lit_t l);
    case (l.sig)
      0: checkVal("lit_reply", WW'(mem_reply), l.v);
      1: checkVal("lit_busy", WW'(busy), l.v);
      2: checkVal("lit_proto_err", WW'(proto_err), l.v);
      default: checkVal("lit_rdata", mem_rdata, l.v);
    endcase
  endtask

  task automatic addEv(int n, bit r, bit w, int a, logic [WW-1:0] d);
    ev_t e;
    e.n = n; e.r = r; e.w = w; e.a = a; e.d = d;
    evq.push_back(e);
  endtask

  task automatic addLit(int n, int sig, logic [WW-1:0] v);
    lit_t l;
    l.n = n; l.sig = sig; l.v = v;
    litq.push_back(l);
  endtask

  task automatic runCycles(int len, int reset_at);
    bit            r;
    bit            w;
    int            a;
    logic [WW-1:0] d;
    for (int c = 0; c < len; c++) begin
      if (c == reset_at) begin
        doReset();
        break;
      end
      r = 1'b0; w = 1'b0; a = 0; d = '0;
      foreach (litq[i]) if (litq[i].n == m_n) checkLit(litq[i]);
      foreach (evq[i]) begin
        if (evq[i].n == m_n) begin
          r = evq[i].r; w = evq[i].w; a = evq[i].a; d = evq[i].d;
        end
      end
      applyStimulus(r, w, a, d);
    end
    evq.delete();
    litq.delete();
  endtask

  initial begin
    @(negedge clk);
    doReset();

    // Give every word a known value so later reads have defined expectations.
    for (int i = 0; i < NW; i++) begin
      applyStimulus(1'b0, 1'b1, i, word_init(i));
      for (int k = 0; k < 40 && m_pend; k++) applyStimulus(1'b0, 1'b0, 0, '0);
    end

    $display("[TB] write then read");
    doReset();
    addEv(0, 0, 1, 5, WW'(32'h1234));
    addEv(26, 1, 0, 5, '0);
    addLit(1, 1, 1);   addLit(11, 0, 0);  addLit(12, 0, 1);  addLit(12, 1, 1);
    addLit(13, 1, 0);  addLit(27, 3, 0);  addLit(28, 0, 1);
    addLit(28, 3, WW'(32'h1234));
    runCycles(31, -1);

    $display("[TB] maximum latency");
    doReset();
    addEv(27, 1, 0, 5, '0);
    addLit(43, 0, 0);  addLit(44, 0, 1);  addLit(44, 3, WW'(32'h1234));  addLit(45, 1, 0);
    runCycles(47, -1);

    $display("[TB] wrap-around write and reply-cycle pulse");
    doReset();
    addEv(16, 0, 1, 7, WW'(32'h7FFF_FFFF));
    addEv(32, 1, 0, 0, '0);
    addEv(33, 1, 0, 0, '0);
    addLit(32, 0, 1);  addLit(32, 2, 0);  addLit(33, 2, 1);
    addLit(50, 0, 1);  addLit(50, 3, word_init(0));
    runCycles(52, -1);

    $display("[TB] wrap-around read");
    doReset();
    addEv(32, 1, 0, 0, '0);
    addEv(36, 1, 0, 7, '0);
    addLit(33, 0, 0);  addLit(34, 0, 1);  addLit(34, 3, word_init(0));
    addLit(48, 0, 1);  addLit(48, 3, WW'(32'h7FFF_FFFF));
    runCycles(50, -1);

    $display("[TB] busy collision");
    doReset();
    addEv(0, 1, 0, 3, '0);
    addEv(2, 0, 1, 6, WW'(32'h1111));
    addEv(10, 1, 0, 6, '0);
    addLit(2, 2, 0);   addLit(3, 2, 1);   addLit(8, 0, 1);
    addLit(8, 3, word_init(3));  addLit(14, 0, 1);  addLit(14, 3, word_init(6));
    runCycles(16, -1);

    $display("[TB] simultaneous pulses");
    doReset();
    addEv(0, 1, 1, 2, WW'(32'h2222));
    addLit(1, 2, 1);   addLit(1, 1, 0);
    runCycles(41, -1);

    $display("[TB] reset mid-operation");
    doReset();
    addEv(0, 0, 1, 6, WW'(32'h55));
    addLit(4, 1, 1);
    runCycles(20, 5);
    addEv(0, 1, 0, 6, '0);
    addLit(0, 2, 0);   addLit(14, 0, 1);  addLit(14, 3, word_init(6));
    runCycles(16, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
